// File: rtl/aes_v3_sub_par.sv
// AES SubBytes unit with NSBOX (1, 2 or 4) S-boxes, stepping through the
// four bytes of a word over 4/NSBOX cycles with a valid/ready handshake.
// Optional build macro AES_V3_SUB_OUTREG_EN registers rd/ready behind a
// DONE state (latency STEPS+1); undefined gives a combinational final step.

// Combined forward/inverse AES S-box computed from the GF(2^8) inverse.
module aes_sbox (
    input  logic       enc,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ t;
            end
            t = xtime(t);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // Forward: affine(inverse(x)); inverse: inverse(affine^-1(x)).
    always_comb begin
        if (enc) begin
            dout = aff_fwd(gf_inv(din));
        end else begin
            dout = gf_inv(aff_inv(din));
        end
    end

endmodule

module aes_v3_sub_par #(
    parameter int unsigned NSBOX = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    input  logic        src,
    output logic        ready,
    output logic        busy,
    output logic [31:0] rd
);

    localparam int unsigned STEPS = 4 / NSBOX;
    localparam int unsigned BASE  = (STEPS - 1) * NSBOX;
    localparam logic [1:0]  LAST  = 2'(STEPS - 1);

    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
        $error("aes_v3_sub_par: NSBOX must be 1, 2 or 4");
    end

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [7:0]  buf_q    [4];
    logic        buf_we;
    logic        sb_en;
    logic [7:0]  in_byte  [4];
    logic [7:0]  sb_in    [NSBOX];
    logic [7:0]  sb_out   [NSBOX];
    logic [7:0]  res_byte [4];
    logic [31:0] res_word;
    logic [31:0] rd_final;
`ifdef AES_V3_SUB_OUTREG_EN
    logic        done_q;
    logic        done_d;
    logic [31:0] rd_q;
`endif

    // Operand byte selection: interleave rs1/rs2 or take every byte from rs1.
    for (genvar k = 0; k < 4; k++) begin : g_in
        if (k % 2 == 0) begin : g_even
            assign in_byte[k] = rs1[8*k +: 8];
        end else begin : g_odd
            assign in_byte[k] = src ? rs1[8*k +: 8] : rs2[8*k +: 8];
        end
    end

    // S-box i sees byte cnt*NSBOX+i; held at zero when idle to cut toggling.
    always_comb begin
        for (int i = 0; i < int'(NSBOX); i++) begin
            sb_in[i] = sb_en ? in_byte[2'(32'(cnt_q) * NSBOX + 32'(i))] : 8'h00;
        end
    end

    for (genvar i = 0; i < int'(NSBOX); i++) begin : g_sbox
        aes_sbox u_sbox (
            .enc  (enc),
            .din  (sb_in[i]),
            .dout (sb_out[i])
        );
    end

    // Final-step word: upper bytes straight from the S-boxes, rest from buffer.
    for (genvar k = 0; k < 4; k++) begin : g_res
        if (k >= int'(BASE)) begin : g_cur
            assign res_byte[k] = sb_out[k - int'(BASE)];
        end else begin : g_buf
            assign res_byte[k] = buf_q[k];
        end
    end

    assign res_word = {res_byte[3], res_byte[2], res_byte[1], res_byte[0]};
    assign rd_final = rot ? {res_word[23:0], res_word[31:24]} : res_word;

    // State register: step counter and (optionally) DONE flag plus result.
    always_ff @(posedge g_clk or posedge g_resetn) begin
        if (g_resetn) begin
            cnt_q  <= 2'd0;
`ifdef AES_V3_SUB_OUTREG_EN
            done_q <= 1'b0;
            rd_q   <= 32'h0;
`endif
        end else begin
            cnt_q  <= cnt_d;
`ifdef AES_V3_SUB_OUTREG_EN
            done_q <= done_d;
            rd_q   <= done_d ? rd_final : 32'h0;
`endif
        end
    end

    // Intermediate byte buffer, filled one step at a time.
    always_ff @(posedge g_clk or posedge g_resetn) begin
        if (g_resetn) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= 8'h00;
            end
        end else if (buf_we) begin
            for (int i = 0; i < int'(NSBOX); i++) begin
                buf_q[2'(32'(cnt_q) * NSBOX + 32'(i))] <= sb_out[i];
            end
        end
    end

    // Next-state: advance on valid, wrap on completion, clear on abort.
    always_comb begin
        cnt_d  = cnt_q;
        buf_we = 1'b0;
        sb_en  = valid;
`ifdef AES_V3_SUB_OUTREG_EN
        done_d = 1'b0;
        sb_en  = valid && !done_q;
        if (done_q) begin
            cnt_d = 2'd0;
        end else if (!valid) begin
            cnt_d = 2'd0;
        end else if (cnt_q == LAST) begin
            cnt_d  = 2'd0;
            done_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 2'd1;
            buf_we = 1'b1;
        end
`else
        if (!valid) begin
            cnt_d = 2'd0;
        end else if (cnt_q == LAST) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d  = cnt_q + 2'd1;
            buf_we = 1'b1;
        end
`endif
    end

    // Outputs: handshake, busy and zero-gated result.
    always_comb begin
`ifdef AES_V3_SUB_OUTREG_EN
        ready = done_q;
        busy  = (cnt_q != 2'd0) || done_q;
        rd    = rd_q;
`else
        ready = valid && (cnt_q == LAST) && !g_resetn;
        busy  = (cnt_q != 2'd0);
        rd    = ready ? rd_final : 32'h0;
`endif
    end

endmodule

// File: tb/tb_aes_v3_sub_par.sv
// Bench for aes_v3_sub_par: three instances (NSBOX = 1, 2, 4) checked every
// cycle against a table-driven SubBytes model and a latency-count model.
module tb_aes_v3_sub_par;

`ifdef AES_V3_SUB_OUTREG_EN
    localparam int unsigned OREG = 1;
`else
    localparam int unsigned OREG = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid [3];
    logic [31:0] rs1   [3];
    logic [31:0] rs2   [3];
    logic        enc   [3];
    logic        rot   [3];
    logic        src   [3];
    logic        ready [3];
    logic        busy  [3];
    logic [31:0] rd    [3];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    int unsigned p   [3] = '{0, 0, 0};
    logic [31:0] cap [3] = '{32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_v3_sub_par #(.NSBOX(1 << g)) u_dut (
            .g_clk    (clk),
            .g_resetn (rst),
            .valid    (valid[g]),
            .rs1      (rs1[g]),
            .rs2      (rs2[g]),
            .enc      (enc[g]),
            .rot      (rot[g]),
            .src      (src[g]),
            .ready    (ready[g]),
            .busy     (busy[g]),
            .rd       (rd[g])
        );
    end

    function automatic int unsigned steps(input int l);
        return 4 >> l;
    endfunction

    function automatic int unsigned lat(input int l);
        return (4 >> l) + OREG;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return r;
    endfunction

    // Whole-word SubBytes result straight from the instruction definition.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic e, input logic r, input logic s);
        logic [7:0]  bt;
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            bt = (s || (k % 2 == 0)) ? a[8*k +: 8] : b[8*k +: 8];
            res[8*k +: 8] = e ? sb[bt] : isb[bt];
        end
        return r ? {res[23:0], res[31:24]} : res;
    endfunction

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d got %h want %h at %0t", nm, l, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int l, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic r, input logic s);
        rs1[l] = a;
        rs2[l] = b;
        enc[l] = e;
        rot[l] = r;
        src[l] = s;
    endtask

    // Issue one request, wait (bounded) for ready, check latency and result.
    task automatic req(input int l, input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic r, input logic s, input logic [31:0] want);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        drive(l, a, b, e, r, s);
        valid[l] = 1'b1;
        while (!hit && n < 20) begin
            @(negedge clk);
            n++;
            if (ready[l]) hit = 1'b1;
        end
        chk("latency", l, 32'(n), 32'(lat(l)));
        chk("rd_done", l, rd[l], want);
        step();
    endtask

    // Progress model: count of consecutive valid cycles in the current request.
    always @(posedge clk or posedge rst) begin : mdl
        for (int l = 0; l < 3; l++) begin
            if (rst) begin
                p[l]   <= 0;
                cap[l] <= 32'h0;
            end else if (!valid[l] || p[l] == lat(l) - 1) begin
                p[l]   <= 0;
                cap[l] <= 32'h0;
            end else begin
                p[l]   <= p[l] + 1;
                cap[l] <= (p[l] + 1 == steps(l)) ? model(rs1[l], rs2[l], enc[l], rot[l], src[l]) : 32'h0;
            end
        end
    end

    // Per-cycle comparison of all three instances against the model.
    always @(negedge clk) begin : cmp
        logic        er;
        logic [31:0] erd;
        for (int l = 0; l < 3; l++) begin
            if (OREG != 0) begin
                er = (p[l] == steps(l));
            end else begin
                er = valid[l] && !rst && (p[l] == steps(l) - 1);
            end
            if (!er) begin
                erd = 32'h0;
            end else if (OREG != 0) begin
                erd = cap[l];
            end else begin
                erd = model(rs1[l], rs2[l], enc[l], rot[l], src[l]);
            end
            chk("ready", l, 32'(ready[l]), 32'(er));
            chk("busy", l, 32'(busy[l]), 32'(p[l] != 0));
            chk("rd", l, rd[l], erd);
        end
    end

    initial begin
        logic [7:0] c;
        c = 8'h63;
        for (int l = 0; l < 3; l++) begin
            valid[l] = 1'b0;
            drive(l, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        // NSBOX=4 lane requests during reset: ready must stay low.
        drive(2, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0);
        valid[2] = 1'b1;

        // Reference tables: brute-force field inverse, then the affine map.
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xv;
            logic [7:0] inv;
            logic [7:0] s;
            xv  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[x]  = s;
            isb[s] = xv;
        end

        chk("pin_sb00", 0, 32'(sb[8'h00]), 32'h63);
        chk("pin_sb01", 0, 32'(sb[8'h01]), 32'h7c);
        chk("pin_sb53", 0, 32'(sb[8'h53]), 32'hed);
        chk("pin_isb63", 0, 32'(isb[8'h63]), 32'h00);
        chk("pin_model", 0, model(32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0), 32'h7c637c63);

        step();
        step();
        chk("rst_ready2", 2, 32'(ready[2]), 32'h0);
        chk("rst_rd2", 2, rd[2], 32'h0);
        valid[2] = 1'b0;
        rst = 1'b0;
        step();

        // Directed requests on every lane, back-to-back.
        for (int l = 0; l < 3; l++) begin
            req(l, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0, 32'h7c637c63);
            req(l, 32'h0, 32'h01010101, 1'b1, 1'b1, 1'b0, 32'h637c637c);
            req(l, 32'h53535353, 32'h0, 1'b1, 1'b0, 1'b1, 32'hedededed);
            req(l, 32'h63636363, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000000);
            valid[l] = 1'b0;
            step();
        end

        // Abort after two cycles, then a full restart.
        drive(0, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0);
        valid[0] = 1'b1;
        step();
        step();
        valid[0] = 1'b0;
        step();
        req(0, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0, 32'h7c637c63);
        valid[0] = 1'b0;
        step();

        // Asynchronous reset in step 2.
        drive(0, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0);
        valid[0] = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 0, 32'(ready[0]), 32'h0);
        chk("arst_busy", 0, 32'(busy[0]), 32'h0);
        chk("arst_rd", 0, rd[0], 32'h0);
        @(negedge clk);
        valid[0] = 1'b0;
        step();
        rst = 1'b0;
        req(0, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0, 32'h7c637c63);
        valid[0] = 1'b0;
        step();

        // Random traffic with aborts and idle gaps.
        for (int l = 0; l < 3; l++) begin
            for (int t = 0; t < 150; t++) begin
                logic [31:0] a;
                logic [31:0] b;
                logic        e;
                logic        r;
                logic        s;
                a = $urandom;
                b = $urandom;
                e = 1'($urandom);
                r = 1'($urandom);
                s = 1'($urandom);
                if ($urandom_range(0, 3) == 0 && lat(l) > 1) begin
                    drive(l, a, b, e, r, s);
                    valid[l] = 1'b1;
                    repeat ($urandom_range(1, lat(l) - 1)) step();
                    valid[l] = 1'b0;
                    drive(l, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
                    step();
                end else begin
                    req(l, a, b, e, r, s, model(a, b, e, r, s));
                end
                if ($urandom_range(0, 1) == 1) begin
                    valid[l] = 1'b0;
                    step();
                end
            end
            valid[l] = 1'b0;
            step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_v3_sub_par.md
Name: aes_v3_sub_par

Overview:
Parametrised successor to the lightweight AES SubBytes unit. It serves the AES SubBytes instructions in the crypto functional unit, and is configured either for small area or for low latency.
- Instantiates NSBOX aes_sbox instances (1, 2 or 4).
- Processes the 4 bytes of a word over 4/NSBOX steps and buffers the intermediate bytes.
- Adds a source-select mode, a clean valid/ready completion with counter return, abort on valid drop, and zero-gated output.

Parameters:
NSBOX, 1, number of S-box instances; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
g_clk  in  1  clock; all state updates on rising edge.
g_resetn  in  1  reset. Asynchronous, active-high (block is in reset while g_resetn=1).
valid  in  1  request; held high until the cycle in which ready=1.
rs1  in  32  source register 1.
rs2  in  32  source register 2.
enc  in  1  1 = forward S-box, 0 = inverse S-box.
rot  in  1  1 = result rotated left by 8 bits.
src  in  1  0 = interleave (even bytes from rs1, odd bytes from rs2); 1 = all bytes from rs1.
ready  out  1  result valid this cycle; the operation completes on valid&&ready.
busy  out  1  operation in progress (step counter non-zero).
rd  out  32  result; forced to 0 whenever ready=0.

Behaviour:
- STEPS = 4/NSBOX. Step counter cnt is 2 bits and resets to 0.
- Reset values:
  - cnt=0, byte buffer=0.
  - ready=0, busy=0, rd=0 throughout reset.
- Byte k (k=0..3):
  - Input byte: src=1 -> rs1[8k+7:8k]. src=0 -> rs1 byte k if k even, rs2 byte k if k odd.
  - Result byte s_k = S(byte k) if enc=1, else S^-1(byte k).
- In step j (cnt=j), sbox i takes byte j*NSBOX+i. S-box inputs are forced to 0 when valid=0, to limit toggling.
- When valid && cnt<STEPS-1:
  - The current sbox outputs are written to buffer bytes j*NSBOX..j*NSBOX+NSBOX-1.
  - cnt <= cnt+1.
- ready = valid && cnt==STEPS-1 && !reset.
- Final step: rd is built combinationally from buffer bytes plus the current sbox outputs.
  - R = {s3,s2,s1,s0}.
  - rd = rot ? {s2,s1,s0,s3} : R.
- Completion: on valid&&ready, cnt <= 0 at the next edge. Back-to-back requests are accepted with no idle cycle.
- Latency is STEPS cycles, counting the first valid cycle: 4 for NSBOX=1, 2 for NSBOX=2, 1 for NSBOX=4 (purely combinational path, no stepping).
- Abort: if valid=0 while cnt!=0, cnt <= 0 at the next edge. Buffer contents are stale; never visible because rd is gated.
- rs1, rs2, enc, src and rot must be stable while valid=1. If they change, the result is undefined but cnt sequencing is unaffected.
- busy = (cnt!=0).
- Asynchronous reset mid-operation: cnt and buffer clear immediately and ready drops. The next valid starts at step 0.

Optional Feature:
Macro AES_V3_SUB_OUTREG_EN.
- Defined:
  - rd and ready are registered. The final-step result is captured at the final-step edge, and a DONE state holds ready=1 from the next cycle.
  - Latency is STEPS+1. cnt/DONE clear on valid&&ready.
  - Abort from DONE returns to step 0 and clears the output register.
  - Output register reset value is 0.
- Undefined: behaviour exactly as above, with a combinational final step.

Test Plan:
1. NSBOX=1, enc=1, src=0, rot=0, rs1=0x00000000, rs2=0x01010101, valid held -> ready=0 on cycles 1-3 and busy=1 on cycles 2-4; ready=1 on cycle 4 with rd=0x7c637c63; cnt=0 the following cycle.
2. Same operands with rot=1 -> rd=0x637c637c. Then back-to-back second request rs1=0x53535353, src=1 -> rd=0xedededed exactly 4 cycles later.
3. Inverse: enc=0, src=1, rs1=0x63636363, NSBOX=2 -> ready on cycle 2, rd=0x00000000. NSBOX=4 -> ready on the same cycle as valid.
4. Abort: NSBOX=1, drop valid after 2 cycles, then restart with test 1 operands -> first completion takes a full 4 cycles and gives rd=0x7c637c63; rd=0 throughout the abort.
5. Reset: assert g_resetn=1 asynchronously in step 2 -> ready=0, busy=0 and rd=0 immediately; after release, test 1 completes normally in 4 cycles.
6. With AES_V3_SUB_OUTREG_EN defined, test 1 -> ready on cycle 5, rd=0x7c637c63, and rd=0 on cycle 4.
